fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the PC loaded on reset (bits [1:0] SHALL be treated as 0).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ic_address  output  32  fetch address to the instruction cache, driven combinationally from the PC register.
REQ-005 SHALL have port ic_data  input  32  instruction word from the cache; valid in the cycle after the address was presented.
REQ-006 SHALL have port ic_hit  input  1  cache hit, registered by the cache; refers to the ic_address of the previous cycle.
REQ-007 SHALL have port redirect  input  1  branch/jump/exception redirect request.
REQ-008 SHALL have port redirect_pc  input  32  redirect target.
REQ-009 SHALL have port out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-010 SHALL have port out_ready  input  1  decode accepts the output this cycle.
REQ-011 SHALL have port out_instr  output  32  fetched instruction.
REQ-012 SHALL have port out_pc  output  32  address of out_instr.

Function
REQ-013 SHALL hold a 32-bit PC register pc; ic_address = pc at all times.
REQ-014 SHALL implement FSM states SETTLE (pc changed last edge; ic_hit stale) and CHECK (ic_hit refers to current pc).
REQ-015 SETTLE SHALL always transition to CHECK on the next edge, ignoring ic_hit and ic_data.
REQ-016 In CHECK, with ic_hit=1 and slot free (out_valid=0 or out_ready=1), SHALL load out_instr<=ic_data, out_pc<=pc, out_valid<=1, pc<=pc+4, and go to SETTLE.
REQ-017 In CHECK, with ic_hit=1 and slot not free, SHALL stay in CHECK with pc and the output register unchanged.
REQ-018 In CHECK, with ic_hit=0 (miss), SHALL stay in CHECK with pc unchanged until a hit arrives; miss duration is unbounded.
REQ-019 SHALL clear out_valid on an edge where out_valid=1, out_ready=1 and no new instruction is loaded.
REQ-020 The output register SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 redirect=1 SHALL take priority over every other event in any state: pc<={redirect_pc[31:2],2'b00}, out_valid<=0 (flush, regardless of out_ready), state<=SETTLE.
REQ-022 pc+4 SHALL be modulo 2^32; 32'hFFFF_FFFC SHALL wrap to 32'h0000_0000.
REQ-023 Peak throughput SHALL be one instruction per two cycles; the latency from pc change to out_valid SHALL be 2 edges on a hit.

Reset
REQ-024 While reset=0, SHALL asynchronously set pc=RESET_PC with bits [1:0] forced to 0, state=SETTLE, out_valid=0, out_instr=0, out_pc=0, and all counters to 0.
REQ-025 Reset asserted mid-fetch or mid-miss SHALL discard the in-flight fetch; no output is produced for it.
REQ-026 After reset deasserts, the first CHECK SHALL occur on the second rising edge.

Configuration
REQ-027 SHALL support macro FETCH_PERF_EN: when defined, SHALL add outputs fetch_count (32, incremented per instruction loaded into the output register) and miss_cycles (32, incremented per CHECK cycle with ic_hit=0 and redirect=0), both wrapping and both reset to 0.
REQ-028 When FETCH_PERF_EN is undefined, those ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Reset, out_ready=1, ic_hit=1 constant, ic_data=32'h2008_0005 -> out_pc sequence 32'h0040_0000, 32'h0040_0004, ...; out_valid high every other cycle.
REQ-030 ic_hit=0 for 5 CHECK cycles at pc=32'h0040_0008 -> pc held, out_valid stays 0 once drained, miss_cycles=5 (FETCH_PERF_EN), then instruction emitted on the hit.
REQ-031 out_ready=0 with out_valid=1 for 4 cycles -> out_instr/out_pc stable, pc not advanced; out_ready=1 -> next instruction loaded on the same edge.
REQ-032 redirect=1, redirect_pc=32'h0040_0103 while out_valid=1 and out_ready=1 -> out_valid=0 next edge, ic_address=32'h0040_0100, first output out_pc=32'h0040_0100.
REQ-033 redirect to 32'hFFFF_FFFC, hit -> out_pc=32'hFFFF_FFFC, then ic_address=32'h0000_0000.
REQ-034 reset pulsed low during a miss at pc=32'h0040_0010 -> pc=32'h0040_0000 immediately, out_valid=0, no output for 32'h0040_0010.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//   Instruction fetch stage. It holds the PC, presents it to the instruction
//   cache, and waits for the cache's registered hit/data response. A fetched
//   word goes into a one-entry output register that decode drains with a
//   valid/ready handshake. A redirect (branch, jump or exception) overrides
//   everything: it reloads the PC and flushes the output register.
//
//   Two-state FSM:
//     SETTLE : the PC changed on the last edge, so ic_hit/ic_data still refer
//              to the old address and are ignored.
//     CHECK  : ic_hit/ic_data refer to the current PC. A hit is consumed when
//              the output slot is free. A miss holds the PC.
//
// Optional build macro:
//   FETCH_PERF_EN - adds the fetch_count and miss_cycles performance counters
//                   and their output ports.
//
// Ports:
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset
//   ic_address   out  32  fetch address, always equal to the PC register
//   ic_data      in   32  instruction word for the previous cycle's address
//   ic_hit       in   1   hit for the previous cycle's address
//   redirect     in   1   redirect request (highest priority)
//   redirect_pc  in   32  redirect target (bits [1:0] ignored)
//   out_valid    out  1   output register holds an instruction
//   out_ready    in   1   decode accepts the output this cycle
//   out_instr    out  32  fetched instruction
//   out_pc       out  32  address of out_instr
//   fetch_count  out  32  [FETCH_PERF_EN] instructions loaded into the output
//   miss_cycles  out  32  [FETCH_PERF_EN] CHECK cycles spent on a miss
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] ic_address,
    input  logic [31:0] ic_data,
    input  logic        ic_hit,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] miss_cycles
`endif
);

    typedef enum logic {
        SETTLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q,    out_pc_d;

    logic slot_free;
    logic load;
    logic miss;

    // Targets are word aligned, so the two low bits of redirect_pc are dropped.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // The slot can take a new word if it is empty or is being drained now.
    assign slot_free = !out_valid_q || out_ready;
    assign load      = !redirect && (state_q == CHECK) && ic_hit && slot_free;
    assign miss      = !redirect && (state_q == CHECK) && !ic_hit;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;

        if (redirect) begin
            // Flush the slot even if decode is not ready: the word is stale.
            pc_d        = {redirect_pc[31:2], 2'b00};
            out_valid_d = 1'b0;
            state_d     = SETTLE;
        end else if (load) begin
            out_instr_d = ic_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;   // wraps modulo 2^32
            state_d     = SETTLE;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            // SETTLE always advances; CHECK holds on a miss or a full slot.
            state_d = CHECK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SETTLE;
            pc_q        <= RESET_PC_ALIGNED;
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_pc_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign ic_address = pc_q;
    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_pc     = out_pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] miss_cycles_q, miss_cycles_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        miss_cycles_d = miss_cycles_q;
        if (load) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (miss) begin
            miss_cycles_d = miss_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 32'd0;
            miss_cycles_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            miss_cycles_q <= miss_cycles_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign miss_cycles = miss_cycles_q;
`else
    logic unused_miss;
    assign unused_miss = miss;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed, table-driven bench for fetch_stage. Each table row is the input
// set applied for one clock cycle plus the outputs expected just after that
// rising edge. Hand-written sequences cover reset and reset during a miss.
// Define FETCH_PERF_EN to also check the performance counters.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] ic_address;
    logic [31:0] ic_data;
    logic        ic_hit;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] miss_cycles;
`endif

    fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .ic_address (ic_address),
        .ic_data    (ic_data),
        .ic_hit     (ic_hit),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count(fetch_count),
        .miss_cycles(miss_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [31:0] rpc;
        logic        hit;
        logic [31:0] data;
        logic        rdy;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[$];
    int   n_checks;
    int   n_pass;

    localparam logic [31:0] I0 = 32'h2008_0005;
    localparam logic [31:0] D1 = 32'h1111_1111;
    localparam logic [31:0] D2 = 32'h2222_2222;
    localparam logic [31:0] D3 = 32'h3333_3333;
    localparam logic [31:0] D4 = 32'h4444_4444;
    localparam logic [31:0] D5 = 32'h5555_5555;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rd, input logic [31:0] rpc, input logic hit,
                       input logic [31:0] data, input logic rdy,
                       input logic [31:0] e_addr, input logic e_v,
                       input logic [31:0] e_instr, input logic [31:0] e_pc);
        vec_t v;
        v.rd = rd; v.rpc = rpc; v.hit = hit; v.data = data; v.rdy = rdy;
        v.e_addr = e_addr; v.e_v = e_v; v.e_instr = e_instr; v.e_pc = e_pc;
        tbl.push_back(v);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // rd rpc hit data rdy | addr v instr pc   (state after the edge)
        // Streaming hits: one instruction every two cycles.
        add(0, 0, 1, I0, 1, 32'h0040_0000, 0, 32'd0, 32'd0);          // 0  SETTLE->CHECK
        add(0, 0, 1, I0, 1, 32'h0040_0004, 1, I0, 32'h0040_0000);     // 1  load
        add(0, 0, 1, I0, 1, 32'h0040_0004, 0, I0, 32'h0040_0000);     // 2  drained
        add(0, 0, 1, I0, 1, 32'h0040_0008, 1, I0, 32'h0040_0004);     // 3  load
        add(0, 0, 1, I0, 1, 32'h0040_0008, 0, I0, 32'h0040_0004);     // 4  to CHECK
        // Five miss cycles at 0x0040_0008, then a hit.
        for (int k = 0; k < 5; k++)
            add(0, 0, 0, 32'd0, 1, 32'h0040_0008, 0, I0, 32'h0040_0004); // 5..9
        add(0, 0, 1, D1, 1, 32'h0040_000C, 1, D1, 32'h0040_0008);     // 10 load on hit
        // Decode stalls for four cycles while a word is waiting.
        for (int k = 0; k < 4; k++)
            add(0, 0, 1, D2, 0, 32'h0040_000C, 1, D1, 32'h0040_0008); // 11..14
        add(0, 0, 1, D2, 1, 32'h0040_0010, 1, D2, 32'h0040_000C);     // 15 drain+load
        // Redirect to an unaligned target while the slot is full and draining.
        add(1, 32'h0040_0103, 1, D2, 1, 32'h0040_0100, 0, D2, 32'h0040_000C); // 16
        add(0, 0, 1, D3, 1, 32'h0040_0100, 0, D2, 32'h0040_000C);     // 17
        add(0, 0, 1, D3, 1, 32'h0040_0104, 1, D3, 32'h0040_0100);     // 18
        // Redirect to the top word, then wrap.
        add(1, 32'hFFFF_FFFC, 1, D3, 1, 32'hFFFF_FFFC, 0, D3, 32'h0040_0100); // 19
        add(0, 0, 1, D4, 1, 32'hFFFF_FFFC, 0, D3, 32'h0040_0100);     // 20
        add(0, 0, 1, D4, 1, 32'h0000_0000, 1, D4, 32'hFFFF_FFFC);     // 21
        // Redirect flushes a full slot even when decode is not ready.
        add(0, 0, 1, D4, 0, 32'h0000_0000, 1, D4, 32'hFFFF_FFFC);     // 22
        add(1, 32'h0040_0010, 1, D4, 0, 32'h0040_0010, 0, D4, 32'hFFFF_FFFC); // 23
        // Miss at 0x0040_0010, interrupted by reset below.
        add(0, 0, 0, 32'd0, 1, 32'h0040_0010, 0, D4, 32'hFFFF_FFFC);  // 24
        add(0, 0, 0, 32'd0, 1, 32'h0040_0010, 0, D4, 32'hFFFF_FFFC);  // 25

        reset       = 1'b0;
        ic_hit      = 1'b0;
        ic_data     = 32'd0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        out_ready   = 1'b1;

        repeat (3) @(negedge clk);
        check32("reset.ic_address", ic_address, 32'h0040_0000);
        check32("reset.out_valid", {31'd0, out_valid}, 32'd0);
        check32("reset.out_instr", out_instr, 32'd0);
        check32("reset.out_pc", out_pc, 32'd0);
`ifdef FETCH_PERF_EN
        check32("reset.fetch_count", fetch_count, 32'd0);
        check32("reset.miss_cycles", miss_cycles, 32'd0);
`endif

        // Release reset at a falling edge; rows then run one per cycle.
        reset = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            redirect    = tbl[i].rd;
            redirect_pc = tbl[i].rpc;
            ic_hit      = tbl[i].hit;
            ic_data     = tbl[i].data;
            out_ready   = tbl[i].rdy;
            @(posedge clk);
            #1;
            check32($sformatf("row%0d.ic_address", i), ic_address, tbl[i].e_addr);
            check32($sformatf("row%0d.out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].e_v});
            check32($sformatf("row%0d.out_instr", i), out_instr, tbl[i].e_instr);
            check32($sformatf("row%0d.out_pc", i), out_pc, tbl[i].e_pc);
`ifdef FETCH_PERF_EN
            if (i == 9) begin
                check32("perf.miss_cycles_after_miss", miss_cycles, 32'd5);
                check32("perf.fetch_count_after_miss", fetch_count, 32'd2);
            end
            if (i == 25) begin
                check32("perf.miss_cycles_end", miss_cycles, 32'd6);
                check32("perf.fetch_count_end", fetch_count, 32'd6);
            end
`endif
            @(negedge clk);
        end

        // Reset asserted in the middle of a cycle during the miss.
        #2;
        reset = 1'b0;
        #1;
        check32("midreset.ic_address", ic_address, 32'h0040_0000);
        check32("midreset.out_valid", {31'd0, out_valid}, 32'd0);
        check32("midreset.out_pc", out_pc, 32'd0);
        check32("midreset.out_instr", out_instr, 32'd0);
`ifdef FETCH_PERF_EN
        check32("midreset.miss_cycles", miss_cycles, 32'd0);
`endif

        @(negedge clk);
        reset     = 1'b1;
        ic_hit    = 1'b1;
        ic_data   = D5;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check32("post_reset.edge1.out_valid", {31'd0, out_valid}, 32'd0);
        check32("post_reset.edge1.ic_address", ic_address, 32'h0040_0000);
        @(posedge clk);
        #1;
        check32("post_reset.edge2.out_valid", {31'd0, out_valid}, 32'd1);
        check32("post_reset.edge2.out_pc", out_pc, 32'h0040_0000);
        check32("post_reset.edge2.out_instr", out_instr, D5);
        check32("post_reset.edge2.ic_address", ic_address, 32'h0040_0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
